// File: rtl/seq_pkg.sv
// Shared types and constants for the seq_ctrl instruction sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_PCUPD,
        ST_HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Instructions that touch data memory and therefore wait on mem_ready.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        return (ic == ICODE_RMMOVQ) || (ic == ICODE_MRMOVQ) || (ic == ICODE_CALL) ||
               (ic == ICODE_RET)    || (ic == ICODE_PUSHQ)  || (ic == ICODE_POPQ);
    endfunction

endpackage

// File: rtl/seq_mem_timer.sv
// MEMORY-state wait counter: cleared outside MEMORY, expires on wait cycle MEM_TIMEOUT.
module seq_mem_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (cnt_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds (wait cycle - 1), so this fires during wait cycle MEM_TIMEOUT.
    assign expired = cnt_en && (count_q == LAST);

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer; define SEQ_CTRL_STEP_EN for single-step mode (step port).
//   state     | meaning
//   IDLE      | waiting for start (or step)
//   FETCH     | latch icode, check fetch errors / halt
//   DECODE    | decode stage
//   EXECUTE   | ALU stage, cc write for OPq
//   MEMORY    | data access, waits on mem_ready for memory-class icodes
//   WRITEBACK | register write stage
//   PCUPD     | retire: bump instr_count
//   HALT      | absorbing until reset
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef SEQ_CTRL_STEP_EN
    input  logic        step,
`endif
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        mem_ready,
    input  logic        dmem_error,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        pc_en,
    output logic        cc_en,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [31:0] instr_count
);

    state_t      state_q, state_d;
    logic [2:0]  stat_q, stat_d;
    logic [3:0]  icode_q, icode_d;
    logic [31:0] count_q, count_d;
    logic        go;
    logic        mem_wait;
    logic        tmr_expired;

`ifdef SEQ_CTRL_STEP_EN
    assign go = start | step;
`else
    assign go = start;
`endif

    assign mem_wait = (state_q == ST_MEMORY) && is_mem_icode(icode_q) && !mem_ready;

    seq_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q != ST_MEMORY),
        .cnt_en  (mem_wait),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        icode_d = icode_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                icode_d = icode;
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = ST_HALT;
                end else if (!instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = ST_HALT;
                end else if (icode == ICODE_HALT) begin
                    stat_d  = STAT_HLT;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: state_d = ST_MEMORY;
            ST_MEMORY: begin
                if (!is_mem_icode(icode_q)) begin
                    state_d = ST_WRITEBACK;
                end else if (mem_ready) begin
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (tmr_expired) begin
                    stat_d  = STAT_ADR;
                    state_d = ST_HALT;
                end
            end
            ST_WRITEBACK: state_d = ST_PCUPD;
            ST_PCUPD: begin
                count_d = count_q + 32'd1;
`ifdef SEQ_CTRL_STEP_EN
                state_d = ST_IDLE;
`else
                state_d = ST_FETCH;
`endif
            end
            ST_HALT: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stat_q  <= STAT_AOK;
            icode_q <= ICODE_HALT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            count_q <= count_d;
        end
    end

    assign fetch_en    = (state_q == ST_FETCH);
    assign decode_en   = (state_q == ST_DECODE);
    assign exec_en     = (state_q == ST_EXECUTE);
    assign mem_en      = (state_q == ST_MEMORY);
    assign wb_en       = (state_q == ST_WRITEBACK);
    assign pc_en       = (state_q == ST_PCUPD);
    assign cc_en       = (state_q == ST_EXECUTE) && (icode_q == ICODE_OPQ);
    assign halted      = (state_q == ST_HALT);
    assign stat        = stat_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: stimulus queues expected retire/halt events, monitor checks them.
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        step;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic        mem_ready;
    logic        dmem_error;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_en;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] instr_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_halt;
        logic [2:0]  stat;
        logic [31:0] cnt;
        int          memc;
        int          cc;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seq_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef SEQ_CTRL_STEP_EN
        .step        (step),
`endif
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .mem_ready   (mem_ready),
        .dmem_error  (dmem_error),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .exec_en     (exec_en),
        .mem_en      (mem_en),
        .wb_en       (wb_en),
        .pc_en       (pc_en),
        .cc_en       (cc_en),
        .stat        (stat),
        .halted      (halted),
        .instr_count (instr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t ret_e(input logic [31:0] cnt, input int memc, input int cc);
        exp_t e;
        e.is_halt = 1'b0; e.stat = 3'd1; e.cnt = cnt;
        e.memc = memc; e.cc = cc; e.cyc = 5 + memc;
        return e;
    endfunction

    function automatic exp_t halt_e(input logic [2:0] st, input logic [31:0] cnt, input int memc);
        exp_t e;
        e.is_halt = 1'b1; e.stat = st; e.cnt = cnt;
        e.memc = memc; e.cc = 0; e.cyc = 0;
        return e;
    endfunction

    // Monitor: tracks per-instruction cycle/cc/memory counts, checks on retire and on halt entry.
    int  m_cyc = 0, m_cc = 0, m_memc = 0;
    bit  prev_halted = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_cyc = 0; m_cc = 0; m_memc = 0; prev_halted = 1'b0;
        end else begin
            if (fetch_en) begin
                m_cyc = 1; m_cc = 0; m_memc = 0;
            end else if (decode_en | exec_en | mem_en | wb_en | pc_en) begin
                m_cyc++;
            end
            if (cc_en) m_cc++;
            if (mem_en) m_memc++;
            if (pc_en || (halted && !prev_halted)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {31'd0, halted}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", {31'd0, halted}, {31'd0, e.is_halt});
                    chk("stat", {29'd0, stat}, {29'd0, e.stat});
                    chk("instr_count", instr_count, e.cnt);
                    chk("mem_cycles", m_memc, e.memc);
                    if (e.is_halt) begin
                        chk("halt_enables", {25'd0, fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_en}, 32'd0);
                    end else begin
                        chk("cc_cycles", m_cc, e.cc);
                        chk("instr_cycles", m_cyc, e.cyc);
                    end
                end
            end
            prev_halted = halted;
        end
    end

    bit need_step = 1'b0;

    task automatic resume();
`ifdef SEQ_CTRL_STEP_EN
        if (need_step) begin
            @(negedge clk);
            chk("step_wait_idle", {31'd0, fetch_en}, 32'd0);
            step = 1'b1;
            @(posedge clk); #1;
            step = 1'b0;
        end
`endif
        need_step = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; step = 1'b0;
        icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
        mem_ready = 1'b0; dmem_error = 1'b0;
        need_step = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_enables", {25'd0, fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_en}, 32'd0);
        chk("rst_stat", {29'd0, stat}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one instruction to retire or halt. mw=0 means mem_ready is never raised.
    task automatic issue(input logic [3:0] ic, input bit valid, input bit ierr, input int mw,
                         input bit derr, input bit scr_en, input logic [3:0] scr, input exp_t e);
        int  k = 0;
        bit  done = 1'b0;
        icode = ic; instr_valid = valid; imem_error = ierr;
        sb.push_back(e);
        resume();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_en) begin
                k++;
                if (mw != 0 && k >= mw) begin
                    mem_ready = 1'b1; dmem_error = derr;
                end
            end
            done = pc_en || halted;
            @(posedge clk); #1;
            mem_ready = 1'b0; dmem_error = 1'b0;
            if (i == 0 && scr_en) icode = scr;
            if (done) break;
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        if (!e.is_halt) need_step = 1'b1;
    endtask

    task automatic check_start_ignored(input logic [2:0] st);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        chk("halt_no_fetch", {31'd0, fetch_en}, 32'd0);
        chk("halt_stat", {29'd0, stat}, {29'd0, st});
    endtask

    initial begin
        int k;
        do_reset();
        icode = 4'h1;
        start_run();
        issue(4'h1, 1, 0, 0, 0, 0, 4'h0, ret_e(0, 1, 0));
        issue(4'h6, 1, 0, 0, 0, 1, 4'h2, ret_e(1, 1, 1));
        issue(4'h2, 1, 0, 0, 0, 0, 4'h0, ret_e(2, 1, 0));
        issue(4'h5, 1, 0, 3, 0, 1, 4'h1, ret_e(3, 3, 0));
        issue(4'h8, 1, 0, 1, 0, 0, 4'h0, ret_e(4, 1, 0));
        issue(4'h3, 1, 0, 0, 0, 0, 4'h0, ret_e(5, 1, 0));
        issue(4'h4, 1, 0, 2, 1, 0, 4'h0, halt_e(3'd3, 6, 2));
        check_start_ignored(3'd3);

        do_reset();
        start_run();
        issue(4'hA, 1, 0, 0, 0, 0, 4'h0, halt_e(3'd3, 0, 15));
        check_start_ignored(3'd3);

        do_reset();
        start_run();
        issue(4'h1, 0, 1, 0, 0, 0, 4'h0, halt_e(3'd3, 0, 0));

        do_reset();
        start_run();
        issue(4'h1, 1, 0, 0, 0, 0, 4'h0, ret_e(0, 1, 0));
        issue(4'h1, 0, 0, 0, 0, 0, 4'h0, halt_e(3'd4, 1, 0));

        do_reset();
        start_run();
        issue(4'h0, 1, 0, 0, 0, 0, 4'h0, halt_e(3'd2, 0, 0));

        // Reset in the middle of a memory wait, then confirm the wait counter restarted.
        do_reset();
        start_run();
        issue(4'h1, 1, 0, 0, 0, 0, 4'h0, ret_e(0, 1, 0));
        icode = 4'h9;
        resume();
        k = 0;
        for (int i = 0; i < 30 && k < 5; i++) begin
            @(negedge clk);
            if (mem_en) k++;
        end
        chk("mid_mem_reached", k, 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_enables", {25'd0, fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_en}, 32'd0);
        chk("midrst_stat", {29'd0, stat}, 32'd1);
        chk("midrst_count", instr_count, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd0);
        @(posedge clk); #1;
        start_run();
        issue(4'hB, 1, 0, 0, 0, 0, 4'h0, halt_e(3'd3, 0, 15));

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the maximum number of MEMORY-state cycles spent waiting for mem_ready.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  begins execution from IDLE; ignored in every other state.
REQ-005 icode  input  4  instruction code from fetch.
REQ-006 instr_valid  input  1  fetch decode of icode is legal.
REQ-007 imem_error  input  1  instruction memory address error.
REQ-008 mem_ready  input  1  data memory access complete this cycle.
REQ-009 dmem_error  input  1  data memory error, sampled only with mem_ready.
REQ-010 fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  output  1 each  one-hot stage enables.
REQ-011 cc_en  output  1  condition-code write enable.
REQ-012 stat  output  3  processor status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-013 halted  output  1  high in HALT state.
REQ-014 instr_count  output  32  retired-instruction counter.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; each stage enable is high exactly in its same-named state.
REQ-016 IDLE->FETCH when start=1; otherwise stay.
REQ-017 FETCH: imem_error=1 -> stat=ADR, HALT; else instr_valid=0 -> stat=INS, HALT; else icode=0 -> stat=HLT, HALT; else DECODE (priority in that order).
REQ-018 DECODE->EXECUTE->MEMORY unconditionally, one cycle each.
REQ-019 cc_en SHALL be high only in EXECUTE with icode=6 (OPq).
REQ-020 MEMORY for icode in {4,5,8,9,A,B}: stay until mem_ready=1; on mem_ready with dmem_error=1 -> stat=ADR, HALT; with dmem_error=0 -> WRITEBACK.
REQ-021 MEMORY wait cycles counted from 1; if mem_ready still 0 after MEM_TIMEOUT cycles -> stat=ADR, HALT.
REQ-022 MEMORY for any other icode: exactly one cycle, mem_ready ignored, -> WRITEBACK.
REQ-023 WRITEBACK->PCUPD; PCUPD increments instr_count (wraps 0xFFFFFFFF->0) and goes to FETCH.
REQ-024 Non-memory instruction, and memory instruction with mem_ready in its first MEMORY cycle: 6 cycles FETCH to PCUPD inclusive.
REQ-025 HALT is absorbing until reset; all enables 0, halted=1, stat and instr_count frozen.
REQ-026 icode is assumed stable FETCH through PCUPD; the block SHALL latch it in FETCH and use the latched value thereafter.

Reset
REQ-027 rst_n=0 at a clock edge from any state, including mid-MEMORY wait: state=IDLE, all enables 0, cc_en=0, stat=AOK, halted=0, instr_count=0, timeout counter=0.

Configuration
REQ-028 Macro SEQ_CTRL_STEP_EN: when defined, an input port step (1 bit) exists and PCUPD goes to IDLE, with the next instruction fetched only on step=1 (start ignored once stepping has begun after reset? no: start and step both accepted in IDLE); when undefined, no step port and PCUPD goes directly to FETCH.

Structure
REQ-029 Shared package seq_pkg SHALL hold stat codes, icode constants (HALT=0, OPq=6, memory-class codes) and the state encoding.
REQ-030 One sub-module, seq_mem_timer, SHALL implement the MEMORY wait counter (clear, count, expire at MEM_TIMEOUT).

Verification
REQ-031 Reset, start=1, icode=1 (nop) valid: enables walk FETCH..PCUPD in 6 cycles, instr_count=1, stat=1.
REQ-032 icode=6: cc_en high only in EXECUTE cycle; icode=2: cc_en never high.
REQ-033 icode=5, mem_ready after 3 wait cycles, dmem_error=0: MEMORY lasts 3 cycles, then WRITEBACK; with dmem_error=1: stat=3, halted=1, instr_count unchanged.
REQ-034 icode=A, mem_ready held 0: after 15 MEMORY cycles stat=3, HALT; later start=1 has no effect.
REQ-035 FETCH with imem_error=1 and instr_valid=0 together: stat=3 (ADR priority); separately instr_valid=0 -> stat=4; icode=0 -> stat=2.
REQ-036 rst_n=0 during MEMORY wait: next cycle IDLE, stat=1, instr_count=0; with SEQ_CTRL_STEP_EN defined, one step pulse retires exactly one instruction.
